// File: rtl/alu_share_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_pkg                                                      |
// | Description : Shared opcodes, FSM state type and datapath width for the   |
// |               ALU sharing controller.                                      |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package alu_pkg;

    localparam int ALU_W = 8;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } alu_state_t;

endpackage
`default_nettype wire

// File: rtl/alu_share_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_share_ctrl_if                                            |
// | Description : Request and response handshake bundle between the           |
// |               requesting engines and the ALU sharing controller.           |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
interface alu_share_ctrl_if
    import alu_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = $clog2(NREQ)
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*ALU_W-1:0] req_a;
    logic [NREQ*ALU_W-1:0] req_b;
    logic [NREQ*3-1:0]     req_op;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [ALU_W-1:0]      rsp_result;
    logic                  rsp_carry;
    logic                  rsp_err;

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_err
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_err
    );
endinterface
`default_nettype wire

// File: rtl/alu_share_ctrl_alu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_8bit                                                     |
// | Description : Combinational 8-bit ALU: ADD, SUB (carry = borrow), AND,     |
// |               OR, XOR; remaining opcodes flag an error.                    |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module alu_8bit
    import alu_pkg::*;
(
    input  wire logic [ALU_W-1:0] a_i,
    input  wire logic [ALU_W-1:0] b_i,
    input  wire logic [2:0]       op_i,
    output logic [ALU_W-1:0]      result_o,
    output logic                  carry_o,
    output logic                  err_o
);

    always_comb begin
        result_o = '0;
        carry_o  = 1'b0;
        err_o    = 1'b0;
        case (op_i)
            OP_ADD:  {carry_o, result_o} = {1'b0, a_i} + {1'b0, b_i};
            // The ninth bit of the wrapped difference is the borrow
            OP_SUB:  {carry_o, result_o} = {1'b0, a_i} - {1'b0, b_i};
            OP_AND:  result_o = a_i & b_i;
            OP_OR:   result_o = a_i | b_i;
            OP_XOR:  result_o = a_i ^ b_i;
            default: err_o = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_share_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_share_ctrl                                               |
// | Description : Round-robin arbiter/sequencer sharing one alu_8bit among     |
// |               NREQ requesters, with tagged registered responses.           |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module alu_share_ctrl
    import alu_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = $clog2(NREQ)
)(
    input  wire logic       clk,
    input  wire logic       rst_n,
    alu_share_ctrl_if.slave bus,
    output logic            busy,
    output logic [15:0]     done_cnt
);

    alu_state_t       state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   id_q, rsp_id_q;
    logic [ALU_W-1:0] a_q, b_q, rsp_result_q;
    logic [2:0]       op_q;
    logic             rsp_carry_q, rsp_err_q;
    logic [15:0]      done_cnt_q, done_cnt_d;

    logic [IDW:0]     pick;
    logic [IDW-1:0]   win;
    logic             accept;
    logic [NREQ-1:0]  req_ready;
    logic [ALU_W-1:0] a_sel, b_sel;
    logic [2:0]       op_sel;
    logic [ALU_W-1:0] alu_result;
    logic             alu_carry, alu_err;

    // Returns {found, index}: first valid requester searching upward from ptr
    function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] valid,
                                             input logic [IDW-1:0]  ptr);
        logic [IDW:0]   res;
        logic [IDW-1:0] idx_w;
        int             idx;
        res = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            idx_w = IDW'(idx);
            if (valid[idx_w]) res = {1'b1, idx_w};
        end
        return res;
    endfunction

    assign pick = rr_pick(bus.req_valid, ptr_q);
    assign win  = pick[IDW-1:0];

    always_comb begin
        a_sel  = '0;
        b_sel  = '0;
        op_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == IDW'(i)) begin
                a_sel  = bus.req_a[i*ALU_W +: ALU_W];
                b_sel  = bus.req_b[i*ALU_W +: ALU_W];
                op_sel = bus.req_op[i*3 +: 3];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        done_cnt_d = done_cnt_q;
        req_ready  = '0;
        accept     = 1'b0;
        case (state_q)
            IDLE: begin
                // rst_n gating keeps req_ready low throughout reset
                if (pick[IDW] && rst_n) begin
                    req_ready[win] = 1'b1;
                    accept         = 1'b1;
                    ptr_d          = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
                    state_d        = EXEC;
                end
            end
            EXEC: state_d = RESP;
            RESP: begin
                if (bus.rsp_ready) begin
                    done_cnt_d = done_cnt_q + 16'd1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            done_cnt_q   <= '0;
            id_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_carry_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            done_cnt_q <= done_cnt_d;
            if (accept) begin
                id_q <= win;
                a_q  <= a_sel;
                b_q  <= b_sel;
                op_q <= op_sel;
            end
            if (state_q == EXEC) begin
                rsp_id_q     <= id_q;
                rsp_result_q <= alu_result;
                rsp_carry_q  <= alu_carry;
                rsp_err_q    <= alu_err;
            end
        end
    end

    alu_8bit u_alu (
        .a_i      (a_q),
        .b_i      (b_q),
        .op_i     (op_q),
        .result_o (alu_result),
        .carry_o  (alu_carry),
        .err_o    (alu_err)
    );

    assign bus.req_ready  = req_ready;
    assign bus.rsp_valid  = (state_q == RESP);
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_carry  = rsp_carry_q;
    assign bus.rsp_err    = rsp_err_q;
    assign busy           = (state_q != IDLE);
    assign done_cnt       = done_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_share_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_alu_share_ctrl                                            |
// | Description : Directed and randomized bench for alu_share_ctrl against a  |
// |               behavioural arbitration/arithmetic model.                   |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_alu_share_ctrl;

    localparam int NREQ = 3;
    localparam int IDW  = $clog2(NREQ);

    logic        clk = 1'b0;
    logic        rst_n;
    logic        busy;
    logic [15:0] done_cnt;

    alu_share_ctrl_if #(.NREQ(NREQ)) bus ();

    alu_share_ctrl #(.NREQ(NREQ)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .busy     (busy),
        .done_cnt (done_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit run_cmp = 1'b0;

    // Model: age -1 = no command held, 0 = computing, 1 = presenting response
    int m_age  = -1;
    int m_ptr  = 0;
    int m_done = 0;
    int m_id, m_res, m_carry, m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void ref_alu(input int a, input int b, input int op,
                                    output int res, output int carry, output int err);
        res = 0; carry = 0; err = 0;
        case (op)
            0: begin res = (a + b) % 256; carry = (a + b > 255) ? 1 : 0; end
            1: begin res = (a - b + 256) % 256; carry = (a < b) ? 1 : 0; end
            2: res = a & b;
            3: res = a | b;
            4: res = a ^ b;
            default: err = 1;
        endcase
    endfunction

    always @(negedge clk) begin : cmp
        int win;
        int exp_ready;
        logic [NREQ*8-1:0] sa, sb;
        logic [NREQ*3-1:0] so;
        if (run_cmp) begin
            win = -1;
            if (rst_n && m_age < 0) begin
                for (int k = 0; k < NREQ; k++) begin
                    int idx;
                    idx = (m_ptr + k) % NREQ;
                    if (win < 0 && ((int'(bus.req_valid) >> idx) & 1) != 0) win = idx;
                end
            end
            exp_ready = (win >= 0) ? (1 << win) : 0;
            chk("req_ready", 32'(bus.req_ready), exp_ready);
            chk("rsp_valid", 32'(bus.rsp_valid), 32'(rst_n && m_age >= 1));
            chk("busy", 32'(busy), 32'(rst_n && m_age >= 0));
            chk("done_cnt", 32'(done_cnt), rst_n ? m_done : 0);
            if (!rst_n) begin
                chk("rst_rsp_id", 32'(bus.rsp_id), 0);
                chk("rst_rsp_result", 32'(bus.rsp_result), 0);
                chk("rst_rsp_carry", 32'(bus.rsp_carry), 0);
                chk("rst_rsp_err", 32'(bus.rsp_err), 0);
            end else if (m_age >= 1) begin
                chk("rsp_id", 32'(bus.rsp_id), m_id);
                chk("rsp_result", 32'(bus.rsp_result), m_res);
                chk("rsp_carry", 32'(bus.rsp_carry), m_carry);
                chk("rsp_err", 32'(bus.rsp_err), m_err);
            end

            if (!rst_n) begin
                m_age = -1; m_ptr = 0; m_done = 0;
            end else if (m_age < 0) begin
                if (win >= 0) begin
                    sa = bus.req_a >> (8 * win);
                    sb = bus.req_b >> (8 * win);
                    so = bus.req_op >> (3 * win);
                    ref_alu(int'(sa[7:0]), int'(sb[7:0]), int'(so[2:0]), m_res, m_carry, m_err);
                    m_id  = win;
                    m_ptr = (win + 1) % NREQ;
                    m_age = 0;
                end
            end else if (m_age == 0) begin
                m_age = 1;
            end else if (bus.rsp_ready) begin
                m_age  = -1;
                m_done = (m_done + 1) % 65536;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input bit v, input logic [7:0] a,
                           input logic [7:0] b, input logic [2:0] op);
        logic [NREQ*8-1:0] m8, va, vb;
        logic [NREQ*3-1:0] m3, vo;
        m8 = {{(NREQ*8-8){1'b0}}, 8'hFF} << (8 * i);
        va = {{(NREQ*8-8){1'b0}}, a} << (8 * i);
        vb = {{(NREQ*8-8){1'b0}}, b} << (8 * i);
        m3 = {{(NREQ*3-3){1'b0}}, 3'b111} << (3 * i);
        vo = {{(NREQ*3-3){1'b0}}, op} << (3 * i);
        bus.req_a  = (bus.req_a & ~m8) | va;
        bus.req_b  = (bus.req_b & ~m8) | vb;
        bus.req_op = (bus.req_op & ~m3) | vo;
        if (v) bus.req_valid = bus.req_valid | NREQ'(1 << i);
        else   bus.req_valid = bus.req_valid & ~NREQ'(1 << i);
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 8'h00, 8'h00, 3'd0);
    endtask

    // Issues one command and returns at the first negedge showing the response
    task automatic run_cmd(input int i, input logic [7:0] a, input logic [7:0] b,
                           input logic [2:0] op, output int res, output int c,
                           output int e, output int id);
        int n;
        set_req(i, 1'b1, a, b, op);
        n = 0;
        @(negedge clk);
        while (((int'(bus.req_ready) >> i) & 1) == 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("grant_seen", 32'(n < 20), 1);
        tick();
        set_req(i, 1'b0, 8'h00, 8'h00, 3'd0);
        @(negedge clk);
        chk("latency_exec", 32'(bus.rsp_valid), 0);
        @(negedge clk);
        chk("latency_resp", 32'(bus.rsp_valid), 1);
        res = int'(bus.rsp_result);
        c   = int'(bus.rsp_carry);
        e   = int'(bus.rsp_err);
        id  = int'(bus.rsp_id);
    endtask

    task automatic drain();
        int n;
        clear_reqs();
        bus.rsp_ready = 1'b1;
        n = 0;
        while (busy && n < 20) begin
            tick();
            n++;
        end
        chk("drain", 32'(busy), 0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin : main
        int res, c, e, id, n;
        int g[$];
        logic [7:0] hold_res;

        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_op    = '0;
        bus.rsp_ready = 1'b0;
        rst_n         = 1'b1;
        #1 rst_n      = 1'b0;
        run_cmp       = 1'b1;

        // Requests during reset must not see a grant
        set_req(0, 1'b1, 8'h11, 8'h22, 3'd0);
        repeat (3) tick();
        clear_reqs();
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        tick();

        run_cmd(0, 8'hF0, 8'h20, 3'd0, res, c, e, id);
        chk("add_result", res, 32'h10);
        chk("add_carry", c, 1);
        chk("add_err", e, 0);
        chk("add_id", id, 0);
        tick();

        run_cmd(1, 8'h05, 8'h07, 3'd1, res, c, e, id);
        chk("sub_borrow_result", res, 32'hFE);
        chk("sub_borrow_carry", c, 1);
        chk("sub_borrow_id", id, 1);
        tick();
        run_cmd(1, 8'h07, 8'h05, 3'd1, res, c, e, id);
        chk("sub_result", res, 32'h02);
        chk("sub_carry", c, 0);
        tick();
        chk("done_after_three", 32'(done_cnt), 3);

        run_cmd(2, 8'hC3, 8'h5A, 3'd4, res, c, e, id);
        chk("xor_result", res, 32'h99);
        chk("xor_id", id, 2);
        tick();

        // Round robin from a fresh reset
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        set_req(0, 1'b1, 8'h01, 8'h02, 3'd0);
        set_req(1, 1'b1, 8'h0F, 8'h3C, 3'd2);
        n = 0;
        while (g.size() < 4 && n < 40) begin
            @(negedge clk);
            if (bus.req_ready != '0) g.push_back(bus.req_ready[1] ? 1 : 0);
            n++;
        end
        tick();
        clear_reqs();
        tick();
        tick();
        chk("rr_count", g.size(), 4);
        if (g.size() == 4) begin
            chk("rr_grant0", g[0], 0);
            chk("rr_grant1", g[1], 1);
            chk("rr_grant2", g[2], 0);
            chk("rr_grant3", g[3], 1);
        end
        chk("rr_done_cnt", 32'(done_cnt), 4);

        // Backpressure with an illegal opcode
        bus.rsp_ready = 1'b0;
        run_cmd(0, 8'h33, 8'h44, 3'b110, res, c, e, id);
        chk("ill_result", res, 0);
        chk("ill_carry", c, 0);
        chk("ill_err", e, 1);
        tick();
        set_req(1, 1'b1, 8'h01, 8'h01, 3'd0);
        set_req(2, 1'b1, 8'h02, 8'h02, 3'd0);
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", 32'(bus.rsp_valid), 1);
            chk("bp_ready", 32'(bus.req_ready), 0);
            chk("bp_result", 32'(bus.rsp_result), 0);
            chk("bp_err", 32'(bus.rsp_err), 1);
            chk("bp_id", 32'(bus.rsp_id), 0);
        end
        tick();
        drain();

        // Reset while holding a response
        bus.rsp_ready = 1'b0;
        run_cmd(1, 8'h12, 8'h34, 3'd0, res, c, e, id);
        chk("pre_reset_result", res, 32'h46);
        tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.rsp_valid), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_result", 32'(bus.rsp_result), 0);
        chk("mid_rst_done", 32'(done_cnt), 0);
        tick();
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("no_stale_valid", 32'(bus.rsp_valid), 0);
        end
        tick();

        // Counter wrap from a preloaded terminal value
        force dut.done_cnt_q = 16'hFFFF;
        m_done = 65535;
        #2;
        release dut.done_cnt_q;
        @(negedge clk);
        chk("pre_wrap", 32'(done_cnt), 32'hFFFF);
        tick();
        run_cmd(0, 8'h80, 8'h80, 3'd0, res, c, e, id);
        chk("wrap_add_result", res, 0);
        chk("wrap_add_carry", c, 1);
        tick();
        chk("wrap_done", 32'(done_cnt), 0);

        // Randomized traffic, backpressure and occasional reset
        hold_res = 8'h00;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < NREQ; i++)
                set_req(i, $urandom_range(0, 2) != 0, 8'($urandom), 8'($urandom),
                        3'($urandom_range(0, 7)));
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            rst_n = ($urandom_range(0, 299) != 0);
            tick();
            hold_res = hold_res ^ bus.rsp_result;
        end
        rst_n = 1'b1;
        drain();

        run_cmp = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
